uriscv_axil_bridge: RTL and testbench
=====================================

// Module: uriscv_axil_bridge
// PURPOSE
//  Converts the core/TCM external data port (mem_out_*) into a single-outstanding AXI4-Lite master.
//  Sits directly downstream of the TCM, serving data addresses >= 0x80000000 (peripherals, ext memory).
//  Holds responses until the TCM accepts them, so collisions with internal TCM acks never drop one.
// PARAMETERS
//  TIMEOUT_CYCLES  256  AXI wait limit before forced error response (only with URISCV_AXIL_TIMEOUT_EN)
// PORTS
//  clk              in   1   clock, all logic on posedge
//  rst_n            in   1   asynchronous active-low reset
//  mem_rd_i         in   1   read request
//  mem_wr_i         in   4   byte write enables; nonzero = write request
//  mem_addr_i       in   32  request byte address
//  mem_data_wr_i    in   32  write data
//  mem_req_tag_i    in   11  request tag, returned with response
//  mem_accept_o     out  1   request accepted this cycle
//  mem_ack_o        out  1   response valid
//  mem_resp_tag_o   out  11  tag of response
//  mem_data_rd_o    out  32  read data (0 for write responses)
//  mem_resp_accept_i in  1   response consumed when mem_ack_o && mem_resp_accept_i
//  bus_err_o        out  1   high with mem_ack_o when response is an error
//  awvalid_o/awready_i/awaddr_o[31:0]   AXI write address channel
//  wvalid_o/wready_i/wdata_o[31:0]/wstrb_o[3:0]  AXI write data channel
//  bvalid_i/bready_o/bresp_i[1:0]       AXI write response channel
//  arvalid_o/arready_i/araddr_o[31:0]   AXI read address channel
//  rvalid_i/rready_o/rdata_i[31:0]/rresp_i[1:0]  AXI read data channel
// BEHAVIOUR
//  Reset: state IDLE; all AXI valid/ready outputs, mem_ack_o, bus_err_o = 0; mem_accept_o = 1; regs 0.
//  Reset mid-transaction aborts immediately (async); no response is produced.
//  mem_accept_o = (state==IDLE), combinational. On accept, capture addr, data, strb, tag.
//  rd and wr together: write wins, read ignored. mem_addr_i[1:0] forwarded unchanged.
//  FSM:
//   IDLE  : wr!=0 -> WRITE (awvalid_o=wvalid_o=1 next cycle); rd -> READ (arvalid_o=1 next cycle).
//   WRITE : awvalid_o drops after its handshake, wvalid_o after its own; either order or same cycle.
//           both done -> WAIT_B with bready_o=1.
//   WAIT_B: bvalid_i -> RESP; data=0; err = (bresp_i!=2'b00).
//   READ  : arvalid_o held until arready_i -> WAIT_R with rready_o=1.
//   WAIT_R: rvalid_i -> RESP; capture rdata_i; err = (rresp_i!=2'b00).
//   RESP  : mem_ack_o=1, tag/data/bus_err_o stable until mem_resp_accept_i -> IDLE.
//  Latency: accept T, AXI valid T+1; zero-wait slave -> ack at T+3, next accept one cycle after consume.
//  AXI valids never drop before handshake; addr/data/strb stable while valid.
//  bready_o/rready_o asserted only in WAIT_B/WAIT_R; single outstanding transaction always.
// CONFIGURATION
//  URISCV_AXIL_TIMEOUT_EN defined: counter clears on entry to WRITE/READ and counts cycles in
//   WRITE/READ/WAIT_B/WAIT_R; reaching TIMEOUT_CYCLES deasserts all AXI valid/ready,
//   goes to RESP with data=32'h0, bus_err_o=1. Late AXI responses afterwards are ignored
//   (bready_o/rready_o low). Counter width $clog2(TIMEOUT_CYCLES+1).
//  Not defined: no counter, waits indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  uriscv_pkg: bridge state enum (IDLE,WRITE,WAIT_B,READ,WAIT_R,RESP), AXI_RESP_OKAY=2'b00,
//   AXI_RESP_SLVERR=2'b10.
//  Single module, no sub-module; aw/w done flags are two registers inside the FSM.
// TESTING
//  Read 0x80000010 tag 0x123, arready same cycle, rvalid +2, rdata 0xCAFEF00D -> ack, tag 0x123, data 0xCAFEF00D, err 0.
//  Write 0x80000004 wr=4'b0011 data 0x11223344; wready 3 cycles before awready -> aw/w each one handshake, wstrb 0011, ack data 0.
//  rd=1 and wr=4'hF same cycle -> only AW/W issued, no AR.
//  Read completes with mem_resp_accept_i=0 for 4 cycles -> ack/tag/data held, mem_accept_o=0, then IDLE after consume.
//  bresp=2'b10 on write -> ack with bus_err_o=1; rresp=2'b11 on read -> bus_err_o=1.
//  TIMEOUT_EN, TIMEOUT_CYCLES=16, arready never -> arvalid_o drops, ack+bus_err_o=1 at cycle 16; no-macro: stays in READ.

Source files
------------

// File: rtl/uriscv_pkg.sv
// Shared types for the uriscv AXI4-Lite data bridge: FSM state encoding and AXI response codes.
package uriscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_B,
        ST_READ,
        ST_WAIT_R,
        ST_RESP
    } bridge_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/uriscv_axil_bridge.sv
// Single-outstanding AXI4-Lite master for the core/TCM external data port.
// Optional watchdog on the AXI wait: define URISCV_AXIL_TIMEOUT_EN.
module uriscv_axil_bridge
    import uriscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd_i,
    input  logic [3:0]  mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_wr_i,
    input  logic [10:0] mem_req_tag_i,
    output logic        mem_accept_o,
    output logic        mem_ack_o,
    output logic [10:0] mem_resp_tag_o,
    output logic [31:0] mem_data_rd_o,
    input  logic        mem_resp_accept_i,
    output logic        bus_err_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] awaddr_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    input  logic        bvalid_i,
    output logic        bready_o,
    input  logic [1:0]  bresp_i,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i
);

    bridge_state_t state_q, state_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [31:0]   addr_q, wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    strb_q;
    logic [10:0]   tag_q;
    logic          err_q, err_d;
    logic          timeout;
    logic          busy;

    assign busy = (state_q != ST_IDLE) && (state_q != ST_RESP);

`ifdef URISCV_AXIL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Held at zero while idle, so every WRITE/READ entry starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (busy)
            cnt_q <= cnt_q + 1'b1;
        else
            cnt_q <= '0;
    end

    assign timeout = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign mem_accept_o   = (state_q == ST_IDLE);
    assign mem_ack_o      = (state_q == ST_RESP);
    assign mem_resp_tag_o = tag_q;
    assign mem_data_rd_o  = rdata_q;
    assign bus_err_o      = (state_q == ST_RESP) && err_q;

    assign awvalid_o = (state_q == ST_WRITE) && !aw_done_q;
    assign wvalid_o  = (state_q == ST_WRITE) && !w_done_q;
    assign bready_o  = (state_q == ST_WAIT_B);
    assign arvalid_o = (state_q == ST_READ);
    assign rready_o  = (state_q == ST_WAIT_R);
    assign awaddr_o  = addr_q;
    assign araddr_o  = addr_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = strb_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (mem_wr_i != 4'b0000)
                    state_d = ST_WRITE;
                else if (mem_rd_i)
                    state_d = ST_READ;
            end
            ST_WRITE: begin
                if (awvalid_o && awready_i)
                    aw_done_d = 1'b1;
                if (wvalid_o && wready_i)
                    w_done_d = 1'b1;
                if (aw_done_d && w_done_d)
                    state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (bvalid_i) begin
                    state_d = ST_RESP;
                    rdata_d = 32'h0;
                    err_d   = (bresp_i != AXI_RESP_OKAY);
                end
            end
            ST_READ: begin
                if (arready_i)
                    state_d = ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (rvalid_i) begin
                    state_d = ST_RESP;
                    rdata_d = rdata_i;
                    err_d   = (rresp_i != AXI_RESP_OKAY);
                end
            end
            ST_RESP: begin
                if (mem_resp_accept_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A timed-out access abandons the AXI side and reports an error.
        if (timeout) begin
            state_d = ST_RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Request fields are captured only when a request is taken in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            strb_q  <= 4'h0;
            tag_q   <= 11'h0;
        end else if ((state_q == ST_IDLE) && (mem_rd_i || (mem_wr_i != 4'b0000))) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_data_wr_i;
            strb_q  <= mem_wr_i;
            tag_q   <= mem_req_tag_i;
        end
    end

endmodule

// File: tb/tb_uriscv_axil_bridge.sv
// Directed bench for uriscv_axil_bridge: table of AXI transactions plus reset and timeout sequences.
module tb_uriscv_axil_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd_i = 1'b0;
    logic [3:0]  mem_wr_i = 4'h0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_data_wr_i = 32'h0;
    logic [10:0] mem_req_tag_i = 11'h0;
    logic        mem_accept_o;
    logic        mem_ack_o;
    logic [10:0] mem_resp_tag_o;
    logic [31:0] mem_data_rd_o;
    logic        mem_resp_accept_i = 1'b0;
    logic        bus_err_o;
    logic        awvalid_o, awready_i = 1'b0;
    logic [31:0] awaddr_o;
    logic        wvalid_o, wready_i = 1'b0;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        bvalid_i = 1'b0, bready_o;
    logic [1:0]  bresp_i = 2'b00;
    logic        arvalid_o, arready_i = 1'b0;
    logic [31:0] araddr_o;
    logic        rvalid_i = 1'b0, rready_o;
    logic [31:0] rdata_i = 32'h0;
    logic [1:0]  rresp_i = 2'b00;

    int n_chk = 0;
    int n_fail = 0;

    uriscv_axil_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
        .mem_data_wr_i(mem_data_wr_i), .mem_req_tag_i(mem_req_tag_i),
        .mem_accept_o(mem_accept_o), .mem_ack_o(mem_ack_o),
        .mem_resp_tag_o(mem_resp_tag_o), .mem_data_rd_o(mem_data_rd_o),
        .mem_resp_accept_i(mem_resp_accept_i), .bus_err_o(bus_err_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        rd;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [10:0] tag;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rsp_dly;
        int          hold;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and act as an AXI slave with the record's delays.
    task automatic run_txn(input vec_t v);
        logic is_wr;
        int   aw_hs, w_hs, ar_hs, rsp_cnt, first_ack;
        logic done, bad;
        is_wr = (v.wr != 4'h0);
        aw_hs = 0; w_hs = 0; ar_hs = 0; rsp_cnt = 0; first_ack = -1;
        done = 1'b0; bad = 1'b0;
        @(negedge clk);
        chk({v.name, "_accept"}, {31'h0, mem_accept_o}, 32'h1);
        mem_rd_i = v.rd; mem_wr_i = v.wr; mem_addr_i = v.addr;
        mem_data_wr_i = v.wdata; mem_req_tag_i = v.tag;
        @(negedge clk);
        mem_rd_i = 1'b0; mem_wr_i = 4'h0; mem_addr_i = 32'h0;
        mem_data_wr_i = 32'h0; mem_req_tag_i = 11'h0;
        for (int c = 1; c < 200 && !done; c++) begin
            awready_i = is_wr && (c >= 1 + v.aw_dly);
            wready_i  = is_wr && (c >= 1 + v.w_dly);
            arready_i = !is_wr && (c >= 1 + v.ar_dly);
            bvalid_i = 1'b0; rvalid_i = 1'b0;
            if (bready_o || rready_o) begin
                bvalid_i = bready_o && (rsp_cnt >= v.rsp_dly);
                rvalid_i = rready_o && (rsp_cnt >= v.rsp_dly);
                bresp_i = v.resp; rresp_i = v.resp; rdata_i = v.rdata;
                rsp_cnt++;
            end
            if (!is_wr && (awvalid_o || wvalid_o)) bad = 1'b1;
            if (is_wr && arvalid_o) bad = 1'b1;
            if (mem_accept_o) bad = 1'b1;
            if (bus_err_o && !mem_ack_o) bad = 1'b1;
            if (awvalid_o && awready_i) begin
                aw_hs++;
                chk({v.name, "_awaddr"}, awaddr_o, v.addr);
            end
            if (wvalid_o && wready_i) begin
                w_hs++;
                chk({v.name, "_wdata"}, wdata_o, v.wdata);
                chk({v.name, "_wstrb"}, {28'h0, wstrb_o}, {28'h0, v.wr});
            end
            if (arvalid_o && arready_i) begin
                ar_hs++;
                chk({v.name, "_araddr"}, araddr_o, v.addr);
            end
            if (mem_ack_o) begin
                if (first_ack < 0) begin
                    first_ack = c;
                    if (v.exp_lat >= 0)
                        chk({v.name, "_latency"}, c, v.exp_lat);
                end
                chk({v.name, "_tag"}, {21'h0, mem_resp_tag_o}, {21'h0, v.tag});
                chk({v.name, "_data"}, mem_data_rd_o, v.exp_data);
                chk({v.name, "_err"}, {31'h0, bus_err_o}, {31'h0, v.exp_err});
                mem_resp_accept_i = ((c - first_ack) >= v.hold);
                if (mem_resp_accept_i) done = 1'b1;
            end
            @(negedge clk);
        end
        mem_resp_accept_i = 1'b0;
        awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
        bvalid_i = 1'b0; rvalid_i = 1'b0; bresp_i = 2'b00; rresp_i = 2'b00;
        chk({v.name, "_completed"}, {31'h0, done}, 32'h1);
        chk({v.name, "_aw_count"}, aw_hs, is_wr ? 1 : 0);
        chk({v.name, "_w_count"}, w_hs, is_wr ? 1 : 0);
        chk({v.name, "_ar_count"}, ar_hs, is_wr ? 0 : 1);
        chk({v.name, "_protocol"}, {31'h0, bad}, 32'h0);
        chk({v.name, "_idle_after"}, {30'h0, mem_accept_o, mem_ack_o}, 32'h2);
    endtask

    initial begin
        int n_ar, ack_c;
        //          name          rd    wr      addr          wdata         tag     aw w ar rsp hold resp   rdata         exp_data      err  lat
        vecs[0] = '{"rd_basic",   1'b1, 4'h0,   32'h80000010, 32'h0,        11'h123, 0, 0, 0, 1, 0, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 4};
        vecs[1] = '{"wr_w_first", 1'b0, 4'h3,   32'h80000004, 32'h11223344, 11'h055, 3, 0, 0, 0, 0, 2'b00, 32'hFFFFFFFF, 32'h0,        1'b0, 6};
        vecs[2] = '{"rd_and_wr",  1'b1, 4'hF,   32'h80000020, 32'hA5A55A5A, 11'h7FF, 0, 0, 0, 0, 0, 2'b00, 32'hFFFFFFFF, 32'h0,        1'b0, 3};
        vecs[3] = '{"rd_backpr",  1'b1, 4'h0,   32'h80000104, 32'h0,        11'h2AA, 0, 0, 0, 0, 4, 2'b00, 32'h12345678, 32'h12345678, 1'b0, 3};
        vecs[4] = '{"wr_slverr",  1'b0, 4'h8,   32'h80000008, 32'hDEADBEEF, 11'h001, 0, 0, 0, 2, 0, 2'b10, 32'h0,        32'h0,        1'b1, 5};
        vecs[5] = '{"rd_decerr",  1'b1, 4'h0,   32'h80000003, 32'h0,        11'h400, 0, 0, 2, 0, 0, 2'b11, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 5};
        vecs[6] = '{"wr_aw_first",1'b0, 4'h4,   32'hC0000010, 32'h00FF0000, 11'h3C3, 0, 2, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1'b0, 5};
        vecs[7] = '{"wr_zero_wt", 1'b0, 4'hF,   32'h90000000, 32'h89ABCDEF, 11'h0F0, 0, 0, 0, 0, 1, 2'b00, 32'h0,        32'h0,        1'b0, 3};

        // reset state
        #12;
        chk("rst_accept", {31'h0, mem_accept_o}, 32'h1);
        chk("rst_outputs", {25'h0, awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, mem_ack_o, bus_err_o}, 32'h0);
        chk("rst_tag_data", {mem_resp_tag_o, 21'h0} | mem_data_rd_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i]);

        // asynchronous reset in the middle of a read aborts it silently
        @(negedge clk);
        mem_rd_i = 1'b1; mem_addr_i = 32'h80000040; mem_req_tag_i = 11'h111;
        @(negedge clk);
        mem_rd_i = 1'b0;
        chk("midrst_arvalid_before", {31'h0, arvalid_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_arvalid_after", {31'h0, arvalid_o}, 32'h0);
        chk("midrst_accept", {31'h0, mem_accept_o}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_ack", {30'h0, mem_ack_o, arvalid_o}, 32'h0);

        // AR never accepted: watchdog in timeout builds, indefinite wait otherwise
        @(negedge clk);
        mem_rd_i = 1'b1; mem_addr_i = 32'h80000FF0; mem_req_tag_i = 11'h321;
        @(negedge clk);
        mem_rd_i = 1'b0;
        n_ar = 0; ack_c = 0;
        for (int c = 1; c <= 40 && ack_c == 0; c++) begin
            if (arvalid_o) n_ar++;
            if (mem_ack_o) ack_c = c;
            else @(negedge clk);
        end
`ifdef URISCV_AXIL_TIMEOUT_EN
        chk("to_arvalid_cycles", n_ar, 16);
        chk("to_ack_cycle", ack_c, 17);
        chk("to_err", {31'h0, bus_err_o}, 32'h1);
        chk("to_data", mem_data_rd_o, 32'h0);
        chk("to_tag", {21'h0, mem_resp_tag_o}, 32'h321);
        rvalid_i = 1'b1; rdata_i = 32'h55555555; bvalid_i = 1'b1;
        chk("to_late_ready", {30'h0, rready_o, bready_o}, 32'h0);
        @(negedge clk);
        chk("to_ack_held", {30'h0, mem_ack_o, bus_err_o}, 32'h3);
        mem_resp_accept_i = 1'b1;
        @(negedge clk);
        mem_resp_accept_i = 1'b0; rvalid_i = 1'b0; bvalid_i = 1'b0;
        chk("to_idle_after", {30'h0, mem_accept_o, mem_ack_o}, 32'h2);
`else
        chk("nto_arvalid_cycles", n_ar, 40);
        chk("nto_no_ack", ack_c, 0);
        chk("nto_still_read", {31'h0, arvalid_o}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("nto_recovered", {31'h0, mem_accept_o}, 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
